// File: rtl/fir_queue_pkg.sv
// Shared types and default sizing for the FIR sample history queue.
// The optional overrun detector is enabled by QUEUE_OVERRUN_EN.
package fir_queue_pkg;

  localparam int unsigned DEFAULT_DEPTH = 1024;
  localparam int unsigned DEFAULT_TAPS  = 1021;

  typedef enum logic [1:0] {
    FILL,
    IDLE,
    SEQ
  } queue_state_t;

  // Both channels live in one RAM word, so left/right can never skew.
  typedef struct packed {
    logic signed [15:0] lft;
    logic signed [15:0] rght;
  } smpl_pair_t;

endpackage

// File: rtl/dualport_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port on clk.
// Only the read register is reset; the array contents survive reset.
module dualport_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds its value whenever no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fir_smpl_queue.sv
// Stereo sample history buffer replaying the newest TAPS pairs, oldest first, per new sample.
// Define QUEUE_OVERRUN_EN to build the sticky overrun detector.
module fir_smpl_queue
  import fir_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned TAPS  = DEFAULT_TAPS,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        overrun
);

  localparam logic [AW:0]   TAPS_CNT  = TAPS[AW:0];
  localparam logic [AW:0]   TAPS_LAST = TAPS_CNT - 1'b1;
  localparam logic [AW-1:0] TAPS_PTR  = TAPS[AW-1:0];

  queue_state_t state_q, state_d;
  logic [AW-1:0] new_ptr_q, new_ptr_inc;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fill_cnt_q;
  logic [AW:0]   rd_cnt_q;
  logic          seq_q;
  logic          wr_en, rd_en, last_data, frame_start;
  smpl_pair_t    wr_pair, rd_pair;

  assign wr_en       = wrt_smpl && (state_q != SEQ);
  assign new_ptr_inc = new_ptr_q + 1'b1;
  assign rd_en       = (state_q == SEQ) && (rd_cnt_q != TAPS_CNT);
  // The cycle after the last read is the last data cycle of the frame.
  assign last_data   = (state_q == SEQ) && (rd_cnt_q == TAPS_CNT);
  assign frame_start = (state_d == SEQ) && (state_q != SEQ);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (wr_en && (fill_cnt_q == TAPS_LAST)) state_d = SEQ;
      IDLE: if (wr_en) state_d = SEQ;
      SEQ:  if (last_data) state_d = IDLE;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      seq_q      <= 1'b0;
      new_ptr_q  <= '0;
      fill_cnt_q <= '0;
      rd_cnt_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= (state_d == SEQ);
      if (wr_en) begin
        new_ptr_q <= new_ptr_inc;
      end
      if (wr_en && (state_q == FILL)) begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
      // Window start is taken from the pointer after the triggering write.
      if (frame_start) begin
        rd_ptr_q <= new_ptr_inc - TAPS_PTR;
        rd_cnt_q <= '0;
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

  assign wr_pair.lft  = lft_smpl;
  assign wr_pair.rght = rght_smpl;

  dualport_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (new_ptr_q),
    .wdata (wr_pair),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (rd_pair)
  );

  assign sequencing = seq_q;
  assign lft_out    = rd_pair.lft;
  assign rght_out   = rd_pair.rght;

`ifdef QUEUE_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (wrt_smpl && (state_q == SEQ)) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
